// File: rtl/barrel_shift_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_pipe
//  Description : Two-stage pipelined barrel shifter (left/right, logical or
//                rotate) with valid/ready handshakes on both sides and a
//                wrapping count of results handed downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module barrel_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3,    // must equal clog2(WIDTH)
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] op_count
);

    // Stage 1: captured request
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [AMT_W-1:0] r_s1_amt;
    logic             r_s1_dir;
    logic             r_s1_rot;

    // Stage 2: registered result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;

    logic [CNT_W-1:0] r_op_count;

    logic             w_advance1;
    logic             w_advance2;
    logic             w_handoff;
    logic [WIDTH-1:0] w_shift_result;
    logic [2*WIDTH-1:0] w_doubled;

    // Stage 2 may move whenever it is empty or being drained; stage 1 may move
    // whenever it is empty or stage 2 is moving. Ready therefore flows
    // combinationally back from out_ready so a full pipe streams without bubbles.
    assign w_advance2 = !r_s2_valid || out_ready;
    assign w_advance1 = !r_s1_valid || w_advance2;
    assign w_handoff  = r_s2_valid && out_ready;

    assign in_ready  = w_advance1;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign op_count  = r_op_count;

    // Logarithmic shifter: stage k conditionally shifts by 2**k. Rotates are
    // taken from a doubled copy of the operand so wrapped bits fall out naturally.
    always_comb begin
        w_shift_result = r_s1_data;
        w_doubled      = '0;
        for (int k = 0; k < AMT_W; k++) begin
            if (r_s1_amt[k]) begin
                w_doubled = {w_shift_result, w_shift_result};
                case ({r_s1_dir, r_s1_rot})
                    2'b00:   w_shift_result = w_shift_result << (1 << k);
                    2'b10:   w_shift_result = w_shift_result >> (1 << k);
                    2'b01: begin
                        w_doubled      = w_doubled << (1 << k);
                        w_shift_result = w_doubled[2*WIDTH-1:WIDTH];
                    end
                    default: begin
                        w_doubled      = w_doubled >> (1 << k);
                        w_shift_result = w_doubled[WIDTH-1:0];
                    end
                endcase
            end
        end
    end

    // Stage 1 register: load on accept, empty when advancing without a request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_amt   <= '0;
            r_s1_dir   <= 1'b0;
            r_s1_rot   <= 1'b0;
        end else if (w_advance1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_amt  <= in_amt;
                r_s1_dir  <= in_dir;
                r_s1_rot  <= in_rot;
            end
        end
    end

    // Stage 2 register: capture shifter output; held while stalled downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_advance2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_shift_result;
        end
    end

    // Completed-operation counter, wraps silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_handoff) begin
            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_shift_pipe
//  Description : Directed self-checking bench for barrel_shift_pipe with a
//                scoreboard queue of expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_barrel_shift_pipe;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] op_count;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] sb_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    barrel_shift_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit reference: bit i moves to i+a (left) or i-a (right)
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int a,
                                               input logic dir, input logic rot);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!dir) begin
                if (i + a < WIDTH) r[i+a] = d[i];
                else if (rot)      r[i+a-WIDTH] = d[i];
            end else begin
                if (i - a >= 0)    r[i-a] = d[i];
                else if (rot)      r[i-a+WIDTH] = d[i];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one request, wait (bounded) for acceptance, record expected result
    task automatic send(input logic [WIDTH-1:0] d, input int a, input logic dir,
                        input logic rot, input logic [WIDTH-1:0] exp);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a[AMT_W-1:0];
        in_dir   = dir;
        in_rot   = rot;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        checks++;
        assert (w < 50) else begin
            errors++;
            $error("FAIL send_timeout observed=stalled expected=in_ready");
        end
        if (w < 50) begin
            @(posedge clk);
            sb_q.push_back(exp);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then check the counter
    task automatic drain(input string tag);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        checks++;
        assert (w < 100) else begin
            errors++;
            $error("FAIL %s_drain_timeout observed=%0d expected=0 pending", tag, sb_q.size());
        end
        @(posedge clk);
        #1;
        chk({tag, "_op_count"}, op_count, exp_cnt);
    endtask

    // Scoreboard consumer: a handoff happens at the next rising edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL extra_result observed=%0h expected=none", out_data);
            end
            if (sb_q.size() > 0) begin
                chk("result", out_data, sb_q.pop_front());
                exp_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] req_d [3];
        logic [WIDTH-1:0] held;
        logic [CNT_W-1:0] base;
        time              t0;
        int               acc;
        int               a;
        logic             dir;
        logic             rot;
        logic [WIDTH-1:0] d;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_op_count",  op_count,  0);
        chk("rst_in_ready",  in_ready,  1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Rotate with latency checks
        send(8'b11010111, 3, 1'b0, 1'b1, 8'b10111110);
        chk("lat_rotl_early", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_rotl_next", out_valid, 1);
        drain("rotl");
        send(8'b11010111, 3, 1'b1, 1'b1, 8'b11111010);
        chk("lat_rotr_early", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_rotr_next", out_valid, 1);
        drain("rotr");

        // Logical shifts and amount zero in every mode
        send(8'b11010111, 3, 1'b0, 1'b0, 8'b10111000);
        send(8'b11010111, 3, 1'b1, 1'b0, 8'b00011010);
        send(8'b11010111, 0, 1'b0, 1'b0, 8'b11010111);
        send(8'b11010111, 0, 1'b1, 1'b0, 8'b11010111);
        send(8'b11010111, 0, 1'b0, 1'b1, 8'b11010111);
        send(8'b11010111, 0, 1'b1, 1'b1, 8'b11010111);
        drain("logical");

        // Walking right rotate of a single one
        for (int k = 1; k < WIDTH; k++)
            send(8'b00000001, k, 1'b1, 1'b1, model(8'b00000001, k, 1'b1, 1'b1));
        drain("walk");

        // Seven back-to-back requests, full streaming
        base = op_count;
        t0   = $time;
        for (int k = 0; k < 7; k++) begin
            d   = WIDTH'($urandom);
            a   = int'($urandom_range(0, WIDTH-1));
            dir = 1'($urandom);
            rot = 1'($urandom);
            send(d, a, dir, rot, model(d, a, dir, rot));
        end
        chk("b2b_cycles", int'(($time - t0) / 10), 7);
        drain("b2b");
        chk("b2b_count", op_count - base, 7);

        // Downstream stall with three requests offered
        req_d[0] = 8'h3C; req_d[1] = 8'hA5; req_d[2] = 8'h81;
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_data   = req_d[0];
        in_amt    = 3'd2;
        in_dir    = 1'b0;
        in_rot    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready && acc < 3) begin
                @(posedge clk);
                sb_q.push_back(model(req_d[acc], 2, 1'b0, 1'b1));
                acc++;
                #1;
                if (acc < 3) in_data = req_d[acc];
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("stall_accepted", acc, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        held = out_data;
        chk("stall_head_data", held, model(req_d[0], 2, 1'b0, 1'b1));
        @(posedge clk); #1;
        chk("stall_data_stable", out_data, held);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("stall_release");
        send(req_d[2], 2, 1'b0, 1'b1, model(req_d[2], 2, 1'b0, 1'b1));
        drain("stall_third");

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(8'h5A, 1, 1'b0, 1'b0, model(8'h5A, 1, 1'b0, 1'b0));
        send(8'hC3, 4, 1'b1, 1'b1, model(8'hC3, 4, 1'b1, 1'b1));
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data",  out_data,  0);
        chk("async_op_count",  op_count,  0);
        sb_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'hF0, 5, 1'b1, 1'b0, model(8'hF0, 5, 1'b1, 1'b0));
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
